// File: rtl/incr_pipe_if.sv
// incr_pipe_if: valid/ready input and output streams of the incrementer pipeline
interface incr_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] val;
  logic             val_valid;
  logic             val_ready;
  logic [WIDTH-1:0] O;
  logic             O_valid;
  logic             O_ready;
  logic             O_ovf;
  logic [CW-1:0]    count;
  modport master (output val, val_valid, O_ready, input val_ready, O, O_valid, O_ovf, count);
  modport slave  (input val, val_valid, O_ready, output val_ready, O, O_valid, O_ovf, count);
endinterface

// File: rtl/incr_pipe.sv
// incr_pipe: DEPTH registered +INC stages with wrap/saturate, overflow flag and bubble-collapsing flow control
module incr_pipe #(
  parameter int             WIDTH    = 8,
  parameter int             DEPTH    = 2,
  parameter logic [WIDTH-1:0] INC    = 1,
  parameter bit             SATURATE = 1'b0
) (
  input  logic      CLK,
  input  logic      RESETN,
  incr_pipe_if.slave p
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] d   [DEPTH];
  logic [WIDTH-1:0] din [DEPTH];
  logic [WIDTH-1:0] nd  [DEPTH];
  logic [WIDTH:0]   s   [DEPTH];
  logic [DEPTH-1:0] v, f, vin, fin, nf, stall;
  logic [CW-1:0]    cnt;
  logic             in_x, out_x;
  for (genvar k = 0; k < DEPTH; k++) begin : g
    if (k == 0) begin : g_head
      assign din[k] = p.val;
      assign vin[k] = p.val_valid;
      assign fin[k] = 1'b0;
    end else begin : g_body
      assign din[k] = d[k-1];
      assign vin[k] = v[k-1];
      assign fin[k] = f[k-1];
    end
    // a stage stalls only when it and every stage below it hold a word and the consumer refuses
    assign stall[k] = (&v[DEPTH-1:k]) & ~p.O_ready;
    assign s[k]     = {1'b0, din[k]} + {1'b0, INC};
    assign nd[k]    = (SATURATE && s[k][WIDTH]) ? '1 : s[k][WIDTH-1:0];
    assign nf[k]    = fin[k] | s[k][WIDTH];
  end
  assign p.val_ready = ~RESETN | ~stall[0];
  assign p.O         = d[DEPTH-1];
  assign p.O_valid   = v[DEPTH-1];
  assign p.O_ovf     = f[DEPTH-1];
  assign p.count     = cnt;
  assign in_x        = p.val_valid & p.val_ready;
  assign out_x       = p.O_valid & p.O_ready;
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      v   <= '0;
      f   <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) d[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (!stall[i]) begin
          v[i] <= vin[i];
          d[i] <= nd[i];
          f[i] <= nf[i];
        end
      cnt <= (in_x && !out_x) ? cnt + 1'b1 : (!in_x && out_x) ? cnt - 1'b1 : cnt;
    end
  end
endmodule

// File: tb/tb_incr_pipe.sv
// tb_incr_pipe: table vectors, directed flow-control sequences and a randomized scoreboard for incr_pipe
module tb_incr_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [7:0]  val;
  logic        vv, ordy;
  logic [15:0] cval;
  logic        cvv, cordy;
  int errors = 0;
  int checks = 0;
  incr_pipe_if #(.WIDTH(8),  .DEPTH(3)) a ();
  incr_pipe_if #(.WIDTH(8),  .DEPTH(3)) b ();
  incr_pipe_if #(.WIDTH(16), .DEPTH(1)) c ();
  assign a.val = val;  assign a.val_valid = vv;  assign a.O_ready = ordy;
  assign b.val = val;  assign b.val_valid = vv;  assign b.O_ready = ordy;
  assign c.val = cval; assign c.val_valid = cvv; assign c.O_ready = cordy;
  incr_pipe #(.WIDTH(8),  .DEPTH(3), .INC(8'd1),      .SATURATE(1'b0)) u_wrap (.CLK(clk), .RESETN(rst_n), .p(a.slave));
  incr_pipe #(.WIDTH(8),  .DEPTH(3), .INC(8'd1),      .SATURATE(1'b1)) u_sat  (.CLK(clk), .RESETN(rst_n), .p(b.slave));
  incr_pipe #(.WIDTH(16), .DEPTH(1), .INC(16'h0100),  .SATURATE(1'b0)) u_wide (.CLK(clk), .RESETN(rst_n), .p(c.slave));
  typedef struct {
    logic [7:0] v;
    logic [7:0] ow;
    bit         fw;
    logic [7:0] os;
    bit         fs;
  } vec_t;
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  // total added is 3*1; wrap is modulo 256, saturate clamps, overflow when the true sum exceeds 255
  function automatic logic [8:0] ref8(input logic [7:0] x, input bit sat);
    int t;
    t = int'(x) + 3;
    ref8 = {t > 255, (sat && t > 255) ? 8'hFF : t[7:0]};
  endfunction
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    vec_t tab [7];
    int acc, got, lim;
    int pos [$];
    logic [8:0] qw [$];
    logic [8:0] qs [$];
    bit exp_ready, exp_ov, in_x, out_x;
    tab = '{'{8'h00, 8'h03, 1'b0, 8'h03, 1'b0},
            '{8'h01, 8'h04, 1'b0, 8'h04, 1'b0},
            '{8'h02, 8'h05, 1'b0, 8'h05, 1'b0},
            '{8'hFE, 8'h01, 1'b1, 8'hFF, 1'b1},
            '{8'hFC, 8'hFF, 1'b0, 8'hFF, 1'b0},
            '{8'hFD, 8'h00, 1'b1, 8'hFF, 1'b1},
            '{8'h7F, 8'h82, 1'b0, 8'h82, 1'b0}};
    vv = 1'b1; val = 8'h55; ordy = 1'b1;
    cvv = 1'b0; cval = '0; cordy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", a.val_ready, 1);
    chk("rst_valid", a.O_valid, 0);
    chk("rst_data", a.O, 0);
    chk("rst_ovf", a.O_ovf, 0);
    chk("rst_count", a.count, 0);
    rst_n = 1'b1;
    vv = 1'b0;
    repeat (4) begin
      step;
      chk("rst_no_word", a.O_valid, 0);
    end
    for (int j = 0; j < 10; j++) begin
      vv = j < 7;
      if (j < 7) val = tab[j].v;
      #1;
      chk("stream_ready", a.val_ready, 1);
      if (j >= 3) begin
        chk("stream_valid", a.O_valid, 1);
        chk("wrap_data", a.O, tab[j-3].ow);
        chk("wrap_ovf", a.O_ovf, tab[j-3].fw);
        chk("sat_data", b.O, tab[j-3].os);
        chk("sat_ovf", b.O_ovf, tab[j-3].fs);
      end else chk("stream_latency", a.O_valid, 0);
      step;
    end
    vv = 1'b0;
    #1;
    chk("stream_drained", a.count, 0);
    ordy = 1'b0;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      vv = 1'b1;
      val = 8'(8'h10 + acc);
      #1;
      chk("bp_ready", a.val_ready, acc < 3);
      if (a.val_ready) acc++;
      step;
    end
    chk("bp_count", a.count, 3);
    chk("bp_full_ready", a.val_ready, 0);
    chk("bp_hold", a.O, 8'h13);
    step;
    chk("bp_hold2", a.O, 8'h13);
    chk("bp_hold_valid", a.O_valid, 1);
    ordy = 1'b1;
    got = 0;
    for (int n = 0; n < 12 && got < 5; n++) begin
      vv = acc < 5;
      val = 8'(8'h10 + acc);
      #1;
      if (a.O_valid) begin
        chk("bp_order", a.O, 8'h13 + got);
        got++;
      end
      if (vv && a.val_ready) acc++;
      step;
    end
    vv = 1'b0;
    #1;
    chk("bp_delivered", got, 5);
    chk("bp_accepted", acc, 5);
    chk("bp_empty", a.count, 0);
    ordy = 1'b0;
    vv = 1'b1; val = 8'h40;
    step;
    vv = 1'b0;
    step;
    step;
    vv = 1'b1; val = 8'h50;
    #1;
    chk("bubble_ready", a.val_ready, 1);
    step;
    vv = 1'b0;
    step;
    chk("bubble_count", a.count, 2);
    chk("bubble_head", a.O, 8'h43);
    chk("bubble_valid", a.O_valid, 1);
    ordy = 1'b1;
    #1;
    chk("bubble_out1", a.O, 8'h43);
    step;
    chk("bubble_out2", a.O, 8'h53);
    chk("bubble_out2_valid", a.O_valid, 1);
    step;
    chk("bubble_empty", a.O_valid, 0);
    ordy = 1'b0;
    vv = 1'b1; val = 8'h60;
    step;
    val = 8'h61;
    step;
    vv = 1'b0;
    #1;
    chk("mid_count", a.count, 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", a.val_ready, 1);
    step;
    rst_n = 1'b1;
    #1;
    chk("mid_count0", a.count, 0);
    chk("mid_valid0", a.O_valid, 0);
    chk("mid_data0", a.O, 0);
    ordy = 1'b1;
    repeat (4) begin
      step;
      chk("mid_no_stale", a.O_valid, 0);
    end
    cvv = 1'b1; cval = 16'hFF80;
    step;
    cval = 16'h1234;
    #1;
    chk("wide_valid", c.O_valid, 1);
    chk("wide_data", c.O, 16'h0080);
    chk("wide_ovf", c.O_ovf, 1);
    step;
    cvv = 1'b0;
    #1;
    chk("wide_data2", c.O, 16'h1334);
    chk("wide_ovf2", c.O_ovf, 0);
    step;
    chk("wide_empty", c.O_valid, 0);
    // scoreboard: each held word has a stage position; words advance one stage per edge into free space
    for (int n = 0; n < 3000; n++) begin
      vv = $urandom_range(0, 3) != 0;
      val = 8'($urandom);
      ordy = $urandom_range(0, 2) != 0;
      #1;
      exp_ready = !(pos.size() == 3 && !ordy);
      exp_ov = pos.size() > 0 && pos[0] == 2;
      chk("rnd_ready", a.val_ready, exp_ready);
      chk("rnd_valid", a.O_valid, exp_ov);
      chk("rnd_count", a.count, pos.size());
      if (exp_ov) begin
        chk("rnd_wrap", {a.O_ovf, a.O}, qw[0]);
        chk("rnd_sat", {b.O_ovf, b.O}, qs[0]);
      end
      out_x = exp_ov && ordy;
      in_x = vv && exp_ready;
      if (out_x) begin
        void'(pos.pop_front());
        void'(qw.pop_front());
        void'(qs.pop_front());
      end
      for (int i = 0; i < pos.size(); i++) begin
        lim = (i == 0) ? 2 : pos[i-1] - 1;
        pos[i] = (pos[i] + 1 < lim) ? pos[i] + 1 : lim;
      end
      if (in_x) begin
        pos.push_back(0);
        qw.push_back(ref8(val, 1'b0));
        qs.push_back(ref8(val, 1'b1));
      end
      step;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
